// File: rtl/hack_pkg.sv
// Shared Hack ALU definitions: ctrl-word bit indices, a field view of the ctrl word,
// and the ctrl encodings of the 18 standard Hack ALU functions.
package hack_pkg;

  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

  localparam logic [5:0] CTRL_ZERO      = 6'b101010;
  localparam logic [5:0] CTRL_ONE       = 6'b111111;
  localparam logic [5:0] CTRL_MINUS_ONE = 6'b111010;
  localparam logic [5:0] CTRL_X         = 6'b001100;
  localparam logic [5:0] CTRL_Y         = 6'b110000;
  localparam logic [5:0] CTRL_NOT_X     = 6'b001101;
  localparam logic [5:0] CTRL_NOT_Y     = 6'b110001;
  localparam logic [5:0] CTRL_NEG_X     = 6'b001111;
  localparam logic [5:0] CTRL_NEG_Y     = 6'b110011;
  localparam logic [5:0] CTRL_X_PLUS_1  = 6'b011111;
  localparam logic [5:0] CTRL_Y_PLUS_1  = 6'b110111;
  localparam logic [5:0] CTRL_X_MINUS_1 = 6'b001110;
  localparam logic [5:0] CTRL_Y_MINUS_1 = 6'b110010;
  localparam logic [5:0] CTRL_X_PLUS_Y  = 6'b000010;
  localparam logic [5:0] CTRL_X_MINUS_Y = 6'b010011;
  localparam logic [5:0] CTRL_Y_MINUS_X = 6'b000111;
  localparam logic [5:0] CTRL_X_AND_Y   = 6'b000000;
  localparam logic [5:0] CTRL_X_OR_Y    = 6'b010101;

endpackage

// File: rtl/hack_alu_pipe_if.sv
// Handshake and data bundle of the Hack ALU pipeline.
// Carries cy/ov only when HACK_ALU_CARRY_EN is defined.
interface hack_alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       ctrl;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic [WIDTH-1:0] acc;
  logic [15:0]      op_cnt;
`ifdef HACK_ALU_CARRY_EN
  logic             cy;
  logic             ov;

  modport master (
    output in_valid, x, y, ctrl, acc_sel, out_ready,
    input  in_ready, out_valid, out, zr, ng, acc, op_cnt, cy, ov
  );

  modport slave (
    input  in_valid, x, y, ctrl, acc_sel, out_ready,
    output in_ready, out_valid, out, zr, ng, acc, op_cnt, cy, ov
  );
`else
  modport master (
    output in_valid, x, y, ctrl, acc_sel, out_ready,
    input  in_ready, out_valid, out, zr, ng, acc, op_cnt
  );

  modport slave (
    input  in_valid, x, y, ctrl, acc_sel, out_ready,
    output in_ready, out_valid, out, zr, ng, acc, op_cnt
  );
`endif
endinterface

// File: rtl/hack_alu_core.sv
// Combinational back half of the Hack ALU: f (add/and), no, and the zr/ng flags on preset operands.
// Adds carry-out and signed overflow of the adder when HACK_ALU_CARRY_EN is defined.
module hack_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_f,
  input  logic             i_no,
`ifdef HACK_ALU_CARRY_EN
  output logic             o_cy,
  output logic             o_ov,
`endif
  output logic [WIDTH-1:0] o_out,
  output logic             o_zr,
  output logic             o_ng
);

`ifdef HACK_ALU_CARRY_EN
  logic [WIDTH:0]   w_sum;
`else
  logic [WIDTH-1:0] w_sum;
`endif
  logic [WIDTH-1:0] w_fn;

  // Function select, output inversion and flags.
  always_comb begin
`ifdef HACK_ALU_CARRY_EN
    w_sum = {1'b0, i_x} + {1'b0, i_y};
`else
    w_sum = i_x + i_y;
`endif
    if (i_f) begin
      w_fn = w_sum[WIDTH-1:0];
    end else begin
      w_fn = i_x & i_y;
    end
    if (i_no) begin
      o_out = ~w_fn;
    end else begin
      o_out = w_fn;
    end
    o_zr = (o_out == {WIDTH{1'b0}});
    o_ng = o_out[WIDTH-1];
`ifdef HACK_ALU_CARRY_EN
    // Carry/overflow describe the raw adder, so no does not affect them.
    o_cy = i_f & w_sum[WIDTH];
    o_ov = i_f & (i_x[WIDTH-1] == i_y[WIDTH-1]) & (w_sum[WIDTH-1] != i_x[WIDTH-1]);
`endif
  end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage Hack ALU pipeline with valid/ready handshakes, accumulator feedback and a transfer counter.
// Optional cy/ov result outputs are enabled by defining HACK_ALU_CARRY_EN.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  hack_alu_pipe_if.slave bus
);
  import hack_pkg::*;

  ctrl_t            w_ctrl;
  logic [WIDTH-1:0] w_y_src;
  logic [WIDTH-1:0] w_x_z;
  logic [WIDTH-1:0] w_y_z;
  logic [WIDTH-1:0] w_x_pre;
  logic [WIDTH-1:0] w_y_pre;
  logic             w_s2_open;
  logic             w_s1_open;
  logic             w_hazard;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;
  logic             r_s1_f;
  logic             r_s1_no;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic [WIDTH-1:0] r_acc;
  logic [15:0]      r_op_cnt;

  logic [WIDTH-1:0] w_core_out;
  logic             w_core_zr;
  logic             w_core_ng;
`ifdef HACK_ALU_CARRY_EN
  logic             w_core_cy;
  logic             w_core_ov;
  logic             r_cy;
  logic             r_ov;
`endif

  assign w_ctrl  = ctrl_t'(bus.ctrl);
  assign w_y_src = bus.acc_sel ? r_acc : bus.y;
  assign w_x_z   = w_ctrl.zx ? {WIDTH{1'b0}} : bus.x;
  assign w_x_pre = w_ctrl.nx ? ~w_x_z : w_x_z;
  assign w_y_z   = w_ctrl.zy ? {WIDTH{1'b0}} : w_y_src;
  assign w_y_pre = w_ctrl.ny ? ~w_y_z : w_y_z;

  // An acc_sel op must wait until every older result has landed in acc.
  assign w_s2_open  = ~r_s2_valid | bus.out_ready;
  assign w_s1_open  = ~r_s1_valid | w_s2_open;
  assign w_hazard   = bus.acc_sel & (r_s1_valid | r_s2_valid);
  assign w_in_ready = ~rst & w_s1_open & ~w_hazard;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = r_s2_valid & bus.out_ready;

  // Stage 1: preset operands and the f/no controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= {WIDTH{1'b0}};
      r_s1_y     <= {WIDTH{1'b0}};
      r_s1_f     <= 1'b0;
      r_s1_no    <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_x     <= w_x_pre;
      r_s1_y     <= w_y_pre;
      r_s1_f     <= w_ctrl.f;
      r_s1_no    <= w_ctrl.no;
    end else if (w_s2_open) begin
      r_s1_valid <= 1'b0;
    end
  end

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_x   (r_s1_x),
    .i_y   (r_s1_y),
    .i_f   (r_s1_f),
    .i_no  (r_s1_no),
`ifdef HACK_ALU_CARRY_EN
    .o_cy  (w_core_cy),
    .o_ov  (w_core_ov),
`endif
    .o_out (w_core_out),
    .o_zr  (w_core_zr),
    .o_ng  (w_core_ng)
  );

  // Stage 2: result and flags, frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out      <= {WIDTH{1'b0}};
      r_zr       <= 1'b0;
      r_ng       <= 1'b0;
`ifdef HACK_ALU_CARRY_EN
      r_cy       <= 1'b0;
      r_ov       <= 1'b0;
`endif
    end else if (w_s2_open) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_core_out;
        r_zr  <= w_core_zr;
        r_ng  <= w_core_ng;
`ifdef HACK_ALU_CARRY_EN
        r_cy  <= w_core_cy;
        r_ov  <= w_core_ov;
`endif
      end
    end
  end

  // Accumulator and completed-transfer counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= {WIDTH{1'b0}};
      r_op_cnt <= 16'd0;
    end else if (w_out_fire) begin
      r_acc    <= r_out;
      r_op_cnt <= r_op_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out       = r_out;
  assign bus.zr        = r_zr;
  assign bus.ng        = r_ng;
  assign bus.acc       = r_acc;
  assign bus.op_cnt    = r_op_cnt;
`ifdef HACK_ALU_CARRY_EN
  assign bus.cy        = r_cy;
  assign bus.ov        = r_ov;
`endif

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed self-checking bench for hack_alu_pipe (WIDTH=16); carry checks build with HACK_ALU_CARRY_EN.
module tb_hack_alu_pipe;
  import hack_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_cnt;

  logic [15:0] st_x [4] = '{16'd1, 16'd10, 16'h0100, 16'h00FF};
  logic [15:0] st_y [4] = '{16'd2, 16'd20, 16'h0001, 16'h0F0F};
  logic [5:0]  st_c [4] = '{6'b000010, 6'b000010, 6'b000010, 6'b000000};
  logic [15:0] st_e [4] = '{16'd3, 16'd30, 16'h0101, 16'h000F};

  hack_alu_pipe_if #(.WIDTH(16)) bus ();

  hack_alu_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] cv,
                         input logic sel);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.y        = yv;
    bus.ctrl     = cv;
    bus.acc_sel  = sel;
    #1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.acc_sel  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] oe, input logic zre,
                            input logic nge);
    int n = 0;
    bus.out_ready = 1'b1;
    #1;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out"}, 32'(bus.out), 32'(oe));
    check({tag, "_zr"}, 32'(bus.zr), 32'(zre));
    check({tag, "_ng"}, 32'(bus.ng), 32'(nge));
    tick();
    exp_cnt++;
    check({tag, "_acc"}, 32'(bus.acc), 32'(oe));
    check({tag, "_cnt"}, 32'(bus.op_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int cyc;
    n_checks      = 0;
    n_errors      = 0;
    exp_cnt       = 0;
    bus.in_valid  = 1'b0;
    bus.x         = 16'd0;
    bus.y         = 16'd0;
    bus.ctrl      = 6'd0;
    bus.acc_sel   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) tick();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_zr", 32'(bus.zr), 32'd0);
    check("rst_ng", 32'(bus.ng), 32'd0);
    check("rst_acc", 32'(bus.acc), 32'd0);
    check("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Function coverage, one op at a time.
    send_op(16'd5, 16'd3, CTRL_ZERO, 1'b0);
    get_result("zero", 16'h0000, 1'b1, 1'b0);
    send_op(16'd5, 16'd3, CTRL_MINUS_ONE, 1'b0);
    get_result("m1", 16'hFFFF, 1'b0, 1'b1);
    send_op(16'd5, 16'd0, CTRL_NEG_X, 1'b0);
    get_result("negx", 16'hFFFB, 1'b0, 1'b1);
    send_op(16'h00F0, 16'h0FF0, CTRL_X_AND_Y, 1'b0);
    get_result("and", 16'h00F0, 1'b0, 1'b0);
    send_op(16'd3, 16'd5, CTRL_X_MINUS_Y, 1'b0);
    get_result("xmy", 16'hFFFE, 1'b0, 1'b1);
    send_op(16'h00F0, 16'h0F00, CTRL_X_OR_Y, 1'b0);
    get_result("or", 16'h0FF0, 1'b0, 1'b0);
    send_op(16'd0, 16'd0, CTRL_ONE, 1'b0);
    get_result("one", 16'h0001, 1'b0, 1'b0);

    // 5+3 latency, then an acc_sel op held off by the interlock.
    bus.out_ready = 1'b1;
    send_op(16'd5, 16'd3, CTRL_X_PLUS_Y, 1'b0);
    check("add_lat1_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.acc_sel  = 1'b1;
    bus.x        = 16'd1;
    bus.y        = 16'h1234;
    bus.ctrl     = CTRL_X_PLUS_Y;
    #1;
    check("haz_ready_s1", 32'(bus.in_ready), 32'd0);
    tick();
    check("add_lat2_valid", 32'(bus.out_valid), 32'd1);
    check("add_out", 32'(bus.out), 32'd8);
    check("add_zr", 32'(bus.zr), 32'd0);
    check("add_ng", 32'(bus.ng), 32'd0);
    check("haz_ready_s2", 32'(bus.in_ready), 32'd0);
    tick();
    exp_cnt++;
    check("add_acc", 32'(bus.acc), 32'd8);
    check("add_cnt", 32'(bus.op_cnt), 32'(exp_cnt));
    check("haz_ready_empty", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.acc_sel  = 1'b0;
    get_result("acc9", 16'd9, 1'b0, 1'b0);

    // Reset with two ops in flight.
    send_op(16'd1, 16'd1, CTRL_X_PLUS_Y, 1'b0);
    send_op(16'd2, 16'd2, CTRL_X_PLUS_Y, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_acc", 32'(bus.acc), 32'd0);
    check("mid_rst_cnt", 32'(bus.op_cnt), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    rst     = 1'b0;
    exp_cnt = 0;
    #1;
    check("mid_rel_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("no_stale", 32'(bus.out_valid), 32'd0);
      tick();
    end

    // Backpressure: two ops fill the pipe, result held for 3 stalled cycles.
    bus.out_ready = 1'b0;
    send_op(st_x[0], st_y[0], st_c[0], 1'b0);
    send_op(st_x[1], st_y[1], st_c[1], 1'b0);
    bus.in_valid = 1'b1;
    bus.x        = st_x[2];
    bus.y        = st_y[2];
    bus.ctrl     = st_c[2];
    #1;
    check("stall_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_hold", 32'(bus.out), 32'(st_e[0]));
      check("stall_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    sent = 2;
    got  = 0;
    cyc  = 0;
    while (got < 4 && cyc < 40) begin
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        bus.x        = st_x[sent];
        bus.y        = st_y[sent];
        bus.ctrl     = st_c[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid) begin
        check($sformatf("stall_res%0d", got), 32'(bus.out), 32'(st_e[got]));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("stall_count", 32'(got), 32'd4);
    check("stall_op_cnt", 32'(bus.op_cnt), 32'd4);
    check("stall_acc", 32'(bus.acc), 32'h000F);
    exp_cnt = 4;

`ifdef HACK_ALU_CARRY_EN
    bus.out_ready = 1'b1;
    send_op(16'hFFFF, 16'h0001, CTRL_X_PLUS_Y, 1'b0);
    tick();
    check("cy_wrap", 32'(bus.cy), 32'd1);
    check("ov_wrap", 32'(bus.ov), 32'd0);
    get_result("wrap", 16'h0000, 1'b1, 1'b0);
    send_op(16'h7FFF, 16'h0001, CTRL_X_PLUS_Y, 1'b0);
    tick();
    check("cy_sovf", 32'(bus.cy), 32'd0);
    check("ov_sovf", 32'(bus.ov), 32'd1);
    get_result("sovf", 16'h8000, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
